parity_rr_scheduler: RTL and testbench
======================================

PARITY_RR_SCHEDULER -- requirements
Module: parity_rr_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the parity unit (2..8).
REQ-002 Parameter DW, default 8, data width per requester.
REQ-003 Parameter ODD, default 0; 0 = even parity (XOR of all bits), 1 = odd parity (inverted XOR).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester request valid.
REQ-007 req_data  input  NREQ*DW  requester i data at bits [i*DW +: DW].
REQ-008 req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-009 res_valid  output  1  result register holds a valid result.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_id  output  3  index of requester owning the result.
REQ-012 res_data  output  DW  data that produced the result.
REQ-013 res_parity  output  1  parity bit of res_data per ODD.
REQ-014 busy  output  1  high when res_valid high or any req_valid high.

Function
REQ-015 The block SHALL use one result register (states EMPTY, FULL); state = res_valid.
REQ-016 slot_free SHALL be (!res_valid) | res_ready, combinational.
REQ-017 Round-robin pointer ptr (width ceil(log2 NREQ)) SHALL select the winner as the first i with req_valid[i], searching ptr, ptr+1, ... wrapping modulo NREQ.
REQ-018 req_ready[winner] SHALL be high only when slot_free is high and the winner exists; all other req_ready bits low.
REQ-019 req_ready SHALL be combinational from req_valid, ptr, res_valid, res_ready; no dependency on req_data.
REQ-020 A transfer SHALL occur on a cycle with req_valid[i] & req_ready[i]; next edge loads res_data = req_data[i], res_id = i, res_parity = (^req_data[i]) ^ ODD, res_valid = 1, ptr = (i+1) mod NREQ.
REQ-021 Latency SHALL be exactly one cycle from request transfer to res_valid.
REQ-022 On res_valid & res_ready with no new transfer the next edge SHALL clear res_valid; res_data/res_id/res_parity hold last values.
REQ-023 Simultaneous result drain and new transfer SHALL load the new result with res_valid staying 1 (full throughput, one result per cycle).
REQ-024 While res_valid & !res_ready, res_data, res_id, res_parity SHALL remain stable and all req_ready SHALL be low.
REQ-025 ptr SHALL change only on a transfer; idle cycles and stalls leave ptr unchanged.
REQ-026 With a single requester continuously valid, it SHALL be granted every cycle res slot is free.
REQ-027 With all NREQ valid and res_ready=1, grants SHALL cycle 0,1,...,NREQ-1,0 with no requester waiting more than NREQ-1 transfers.
REQ-028 A requester dropping req_valid before transfer SHALL lose arbitration without affecting ptr.

Reset
REQ-029 While reset is high: res_valid=0, res_id=0, res_data=0, res_parity=ODD, ptr=0, req_ready all 0, regardless of clk.
REQ-030 Reset asserted mid-operation SHALL discard any held result immediately (asynchronously); no result is emitted for it after release.
REQ-031 First edge after reset release SHALL arbitrate from ptr=0.

Verification
REQ-032 Reset then req_valid=4'b0001, req_data[0]=8'hA5, res_ready=1 -> one cycle later res_valid=1, res_id=0, res_data=8'hA5, res_parity=0 (ODD=0).
REQ-033 req_valid=4'b1111, data 8'h01,8'h03,8'h07,8'hFF, res_ready=1 for 5 cycles -> res_id sequence 0,1,2,3,0; res_parity 1,0,1,0,1.
REQ-034 Hold res_ready=0 with req_valid=4'b0110 -> one result (res_id=1) loaded, then req_ready=0 and outputs stable for 10 cycles; res_ready=1 -> next res_id=2 loaded same cycle as drain.
REQ-035 ODD=1, req_data[2]=8'h00 alone -> res_parity=1, res_id=2.
REQ-036 Assert reset while res_valid=1 and res_ready=0 -> res_valid drops before next clk edge; after release with req_valid=4'b1000, grant goes to requester 3 and ptr becomes 0.
REQ-037 Random stimulus 10k cycles: scoreboard checks every accepted request appears once, in order, with parity equal to reduction XOR ^ ODD, and at most one req_ready high.

Source files
------------

// File: rtl/parity_rr_scheduler.sv
// parity_rr_scheduler: round-robin arbiter feeding one shared parity unit with a single result register
// Ports:
//   i_clk        clock, all state on rising edge
//   i_reset      asynchronous active-high reset
//   i_req_valid  per-requester request valid            [NREQ]
//   i_req_data   requester i data at [i*DW +: DW]       [NREQ*DW]
//   o_req_ready  per-requester accept, at most one high [NREQ]
//   o_res_valid  result register holds a valid result
//   i_res_ready  consumer accepts the result
//   o_res_id     index of the requester owning the result [3]
//   o_res_data   data that produced the result            [DW]
//   o_res_parity parity of o_res_data (even, or odd when ODD=1)
//   o_busy       result held or any request pending
module parity_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int ODD  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*DW-1:0]   i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [2:0]           o_res_id,
    output logic [DW-1:0]        o_res_data,
    output logic                 o_res_parity,
    output logic                 o_busy
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt, w_win, w_idx;
    logic [PW:0]   w_sum;
    logic          w_found, w_slot_free, w_xfer;
    logic [DW-1:0] w_data, r_data;
    logic [2:0]    r_id;
    logic          r_parity;
    // Search ptr, ptr+1, ... wrapping; ptr and offset are both below NREQ,
    // so a single conditional subtract implements the modulo.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            w_idx = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_win == PW'(i)) w_data = i_req_data[i*DW +: DW];
    end
    assign w_slot_free = !o_res_valid || i_res_ready;
    // Gating with reset keeps every ready low while reset is held.
    assign w_xfer      = w_slot_free && w_found && !i_reset;
    assign w_ptr_nxt   = (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;
    always_comb begin
        o_req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            o_req_ready[i] = w_xfer && (w_win == PW'(i));
    end
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = w_xfer ? FULL : (i_res_ready ? EMPTY : r_state);
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= EMPTY;
        else         r_state <= w_state_nxt;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data   <= '0;
            r_id     <= '0;
            r_parity <= 1'(ODD);
            r_ptr    <= '0;
        end else if (w_xfer) begin
            r_data   <= w_data;
            r_id     <= 3'(w_win);
            r_parity <= (^w_data) ^ 1'(ODD);
            r_ptr    <= w_ptr_nxt;
        end
    end
    assign o_res_valid  = (r_state == FULL);
    assign o_res_id     = r_id;
    assign o_res_data   = r_data;
    assign o_res_parity = r_parity;
    assign o_busy       = o_res_valid || (|i_req_valid);
endmodule

// File: tb/tb_parity_rr_scheduler.sv
// tb_parity_rr_scheduler: directed and randomized checks of parity_rr_scheduler against a queue-based model
module tb_parity_rr_scheduler;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic              res_ready;
    logic [NREQ-1:0]   req_ready, o_req_ready;
    logic              res_valid, o_res_valid;
    logic [2:0]        res_id, o_res_id;
    logic [DW-1:0]     res_data, o_res_data;
    logic              res_parity, o_res_parity;
    logic              busy, o_busy;
    int err = 0;
    int chk = 0;
    typedef struct packed {
        logic [2:0]    id;
        logic [DW-1:0] data;
    } res_t;
    res_t q[$];
    res_t last;
    int   m_ptr;
    parity_rr_scheduler #(.NREQ(NREQ), .DW(DW), .ODD(0)) u_even (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_id(res_id), .o_res_data(res_data), .o_res_parity(res_parity), .o_busy(busy)
    );
    parity_rr_scheduler #(.NREQ(NREQ), .DW(DW), .ODD(1)) u_odd (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(o_req_ready), .o_res_valid(o_res_valid), .i_res_ready(res_ready),
        .o_res_id(o_res_id), .o_res_data(o_res_data), .o_res_parity(o_res_parity), .o_busy(o_busy)
    );
    always #5 clk = ~clk;
    function automatic int winner();
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction
    function automatic logic par(input logic [DW-1:0] d, input int odd);
        return 1'(($countones(d) + odd) % 2);
    endfunction
    task automatic model_reset();
        q.delete();
        m_ptr = 0;
        last  = '0;
    endtask
    task automatic check_outputs(input string tag);
        logic [NREQ-1:0] er;
        int   w;
        logic ev;
        res_t e;
        w  = winner();
        ev = (q.size() != 0);
        e  = ev ? q[0] : last;
        er = '0;
        if (w >= 0 && (!ev || res_ready)) er[w] = 1'b1;
        chk++; if (req_ready !== er) begin err++; $display("FAIL %s req_ready got=%b exp=%b", tag, req_ready, er); end
        chk++; if (o_req_ready !== er) begin err++; $display("FAIL %s odd req_ready got=%b exp=%b", tag, o_req_ready, er); end
        chk++; if ($countones(req_ready) > 1) begin err++; $display("FAIL %s ready_onehot got=%b exp=at most one", tag, req_ready); end
        chk++; if (res_valid !== ev) begin err++; $display("FAIL %s res_valid got=%b exp=%b", tag, res_valid, ev); end
        chk++; if (o_res_valid !== ev) begin err++; $display("FAIL %s odd res_valid got=%b exp=%b", tag, o_res_valid, ev); end
        chk++; if (res_id !== e.id) begin err++; $display("FAIL %s res_id got=%0d exp=%0d", tag, res_id, e.id); end
        chk++; if (res_data !== e.data) begin err++; $display("FAIL %s res_data got=%h exp=%h", tag, res_data, e.data); end
        chk++; if (res_parity !== par(e.data, 0)) begin err++; $display("FAIL %s res_parity got=%b exp=%b", tag, res_parity, par(e.data, 0)); end
        chk++; if (o_res_parity !== par(e.data, 1)) begin err++; $display("FAIL %s odd res_parity got=%b exp=%b", tag, o_res_parity, par(e.data, 1)); end
        chk++; if (o_res_id !== e.id) begin err++; $display("FAIL %s odd res_id got=%0d exp=%0d", tag, o_res_id, e.id); end
        chk++; if (busy !== (ev || (|req_valid))) begin err++; $display("FAIL %s busy got=%b exp=%b", tag, busy, ev || (|req_valid)); end
    endtask
    // Check the combinational view, cross one clock edge, then advance the model.
    task automatic cycle(input string tag);
        int   w;
        logic drain, xfer;
        res_t n;
        #1;
        check_outputs(tag);
        w     = winner();
        drain = (q.size() != 0) && res_ready;
        xfer  = (w >= 0) && ((q.size() == 0) || res_ready);
        if (w >= 0) n = '{id: 3'(w), data: req_data[w*DW +: DW]};
        else        n = '0;
        @(posedge clk);
        if (drain) last = q.pop_front();
        if (xfer) begin
            q.push_back(n);
            m_ptr = (w + 1) % NREQ;
        end
        #1;
    endtask
    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask
    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        req_data  = 32'hDEADBEEF;
        res_ready = 1'b1;
        #3;
        chk++; if (req_ready !== '0) begin err++; $display("FAIL reset req_ready got=%b exp=0", req_ready); end
        chk++; if (res_valid !== 1'b0) begin err++; $display("FAIL reset res_valid got=%b exp=0", res_valid); end
        chk++; if (res_id !== 3'd0) begin err++; $display("FAIL reset res_id got=%0d exp=0", res_id); end
        chk++; if (res_data !== 8'h00) begin err++; $display("FAIL reset res_data got=%h exp=00", res_data); end
        chk++; if (res_parity !== 1'b0) begin err++; $display("FAIL reset res_parity got=%b exp=0", res_parity); end
        chk++; if (o_res_parity !== 1'b1) begin err++; $display("FAIL reset odd res_parity got=%b exp=1", o_res_parity); end
        chk++; if (busy !== 1'b1) begin err++; $display("FAIL reset busy got=%b exp=1", busy); end
        do_reset();
    endtask
    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        req_data  = {8'h11, 8'h22, 8'h33, 8'hA5};
        res_ready = 1'b1;
        cycle("single");
        req_valid = '0;
        #1;
        chk++; if (res_valid !== 1'b1) begin err++; $display("FAIL single res_valid got=%b exp=1", res_valid); end
        chk++; if (res_id !== 3'd0) begin err++; $display("FAIL single res_id got=%0d exp=0", res_id); end
        chk++; if (res_data !== 8'hA5) begin err++; $display("FAIL single res_data got=%h exp=a5", res_data); end
        chk++; if (res_parity !== 1'b0) begin err++; $display("FAIL single res_parity got=%b exp=0", res_parity); end
        cycle("single_drain");
        cycle("single_idle");
    endtask
    task automatic test_round_robin();
        logic [2:0] ids [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic       pars[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        req_valid = 4'b1111;
        req_data  = {8'hFF, 8'h07, 8'h03, 8'h01};
        res_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cycle("rr");
            chk++; if (res_id !== ids[n]) begin err++; $display("FAIL rr[%0d] res_id got=%0d exp=%0d", n, res_id, ids[n]); end
            chk++; if (res_parity !== pars[n]) begin err++; $display("FAIL rr[%0d] res_parity got=%b exp=%b", n, res_parity, pars[n]); end
        end
        req_valid = '0;
        cycle("rr_drain");
    endtask
    task automatic test_stall();
        do_reset();
        req_valid = 4'b0110;
        req_data  = {8'h44, 8'h3C, 8'h81, 8'h00};
        res_ready = 1'b0;
        cycle("stall_load");
        for (int n = 0; n < 10; n++) cycle("stall_hold");
        chk++; if (res_id !== 3'd1 || req_ready !== '0) begin err++; $display("FAIL stall hold res_id=%0d ready=%b exp id=1 ready=0000", res_id, req_ready); end
        res_ready = 1'b1;
        cycle("stall_release");
        chk++; if (res_id !== 3'd2 || res_valid !== 1'b1) begin err++; $display("FAIL stall next res_id=%0d valid=%b exp id=2 valid=1", res_id, res_valid); end
        req_valid = '0;
        cycle("stall_drain");
    endtask
    task automatic test_odd();
        do_reset();
        req_valid = 4'b0100;
        req_data  = {8'h5A, 8'h00, 8'h77, 8'h01};
        res_ready = 1'b1;
        cycle("odd");
        chk++; if (o_res_parity !== 1'b1 || o_res_id !== 3'd2) begin err++; $display("FAIL odd zero parity=%b id=%0d exp parity=1 id=2", o_res_parity, o_res_id); end
        req_valid = '0;
        cycle("odd_drain");
    endtask
    task automatic test_back_to_back();
        do_reset();
        req_valid = 4'b0100;
        res_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            req_data = $urandom;
            cycle("b2b");
            chk++; if (res_valid !== 1'b1 || res_data !== req_data[23:16]) begin err++; $display("FAIL b2b[%0d] valid=%b data=%h exp valid=1 data=%h", n, res_valid, res_data, req_data[23:16]); end
        end
        req_valid = '0;
        cycle("b2b_drain");
    endtask
    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b0001;
        req_data  = {8'h00, 8'h00, 8'h00, 8'hC3};
        res_ready = 1'b0;
        cycle("arst_load");
        req_valid = '0;
        #2 reset = 1'b1;
        #1;
        chk++; if (res_valid !== 1'b0) begin err++; $display("FAIL arst res_valid got=%b exp=0", res_valid); end
        chk++; if (res_data !== 8'h00 || req_ready !== '0) begin err++; $display("FAIL arst data=%h ready=%b exp data=00 ready=0000", res_data, req_ready); end
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        req_valid = 4'b1000;
        res_ready = 1'b1;
        cycle("arst_grant3");
        chk++; if (res_id !== 3'd3) begin err++; $display("FAIL arst grant res_id got=%0d exp=3", res_id); end
        req_valid = 4'b1111;
        #1;
        chk++; if (req_ready !== 4'b0001) begin err++; $display("FAIL arst ptr_wrap req_ready got=%b exp=0001", req_ready); end
        cycle("arst_wrap");
        req_valid = '0;
        cycle("arst_drain");
    endtask
    task automatic test_random();
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            req_valid = NREQ'($urandom);
            req_data  = $urandom;
            res_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end
    endtask
    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_odd();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule
